epmp_call_ret_ctrl: RTL and testbench

//  Call/return sequencer for the EPMP hardware stack: initiator side of the Push_Stack/Pop_Stack/IB protocol.
//  On CALL it drives the return address onto IBH/IBL, pulses Push_Stack, then loads the PC with the target.
//  On RET it pulses Pop_Stack, captures the popped word from IBH/IBL, then loads the PC with it.

---
 rtl/epmp_pkg.sv | 21 ++
 rtl/epmp_depth_tracker.sv | 78 +++++++
 rtl/epmp_call_ret_ctrl.sv | 141 ++++++++++++++
 tb/tb_epmp_call_ret_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/epmp_pkg.sv
// -----------------------------------------------------------------------------
// epmp_pkg
// Shared definitions for the EPMP call/return sequencer.
//   EPMP_ADDR_W      : width of program addresses and stack words
//   EPMP_STACK_DEPTH : default number of entries in the attached hardware stack
//   epmp_state_e     : sequencer state encoding
// -----------------------------------------------------------------------------
package epmp_pkg;

    localparam int EPMP_ADDR_W      = 16;
    localparam int EPMP_STACK_DEPTH = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALL  = 3'd1,
        CLOAD = 3'd2,
        RET   = 3'd3,
        RLOAD = 3'd4
    } epmp_state_e;

endpackage

// File: rtl/epmp_depth_tracker.sv
// -----------------------------------------------------------------------------
// epmp_depth_tracker
// Mirrors the occupancy of the attached hardware stack and keeps sticky
// overflow/underflow flags.
// Ports:
//   clk_i, rst_i   : clock and asynchronous active-high reset
//   push_i, pop_i  : one-cycle strobes, counted on the edge that ends them
//   flag_clr_i     : synchronous clear of ovf_o/unf_o, wins over a same-cycle set
//   depth_o        : current occupancy, 0..STACK_DEPTH
//   ovf_o, unf_o   : sticky overflow / underflow flags
// -----------------------------------------------------------------------------
module epmp_depth_tracker
    import epmp_pkg::*;
#(
    parameter int STACK_DEPTH = EPMP_STACK_DEPTH,
    parameter int DEPTH_W     = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flag_clr_i,
    output logic [DEPTH_W-1:0] depth_o,
    output logic               ovf_o,
    output logic               unf_o
);

    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;

    // A push into a full stack still happens on the stack side (oldest entry
    // falls off), so the count saturates and only the flag records the loss.
    // Popping an empty stack likewise leaves the count at zero and flags it.
    // The clear is applied last so that it overrides a set in the same cycle.
    always_comb begin
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (push_i) begin
            if (depth_q == DEPTH_MAX) begin
                ovf_d = 1'b1;
            end else begin
                depth_d = depth_q + 1'b1;
            end
        end else if (pop_i) begin
            if (depth_q == '0) begin
                unf_d = 1'b1;
            end else begin
                depth_d = depth_q - 1'b1;
            end
        end
        if (flag_clr_i) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    // Occupancy and flag registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign depth_o = depth_q;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

endmodule

// File: rtl/epmp_call_ret_ctrl.sv
// -----------------------------------------------------------------------------
// epmp_call_ret_ctrl
// Call/return sequencer: initiator side of the Push_Stack/Pop_Stack/IB
// protocol of the EPMP hardware stack.
//   CALL: IDLE -> CALL (drive return address on IB, Push_Stack) -> CLOAD (load target)
//   RET : IDLE -> RET  (Pop_Stack, capture IB)                  -> RLOAD (load popped word)
// Ports:
//   clk, Reset          : clock and asynchronous active-high reset
//   Call_Req, Ret_Req   : decoder requests, sampled only in IDLE (CALL wins)
//   Target, PC_In       : call target and current PC, latched with Call_Req
//   Flag_Clr            : synchronous clear of Ovf/Unf
//   Push_Stack/Pop_Stack: one-cycle stack strobes
//   IBH, IBL            : shared internal bus, driven only in CALL
//   PC_Out, PC_Load     : new PC value and its one-cycle load strobe
//   Busy, Done          : not-IDLE indicator and completion pulse
//   Depth, Ovf, Unf     : stack occupancy and sticky overflow/underflow flags
// -----------------------------------------------------------------------------
module epmp_call_ret_ctrl
    import epmp_pkg::*;
#(
    parameter int STACK_DEPTH = EPMP_STACK_DEPTH,
    parameter int DEPTH_W     = 3
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic                   Call_Req,
    input  logic                   Ret_Req,
    input  logic [EPMP_ADDR_W-1:0] Target,
    input  logic [EPMP_ADDR_W-1:0] PC_In,
    input  logic                   Flag_Clr,
    output logic                   Push_Stack,
    output logic                   Pop_Stack,
    inout  wire  [7:0]             IBH,
    inout  wire  [7:0]             IBL,
    output logic [EPMP_ADDR_W-1:0] PC_Out,
    output logic                   PC_Load,
    output logic                   Busy,
    output logic                   Done,
    output logic [DEPTH_W-1:0]     Depth,
    output logic                   Ovf,
    output logic                   Unf
);

    epmp_state_e            state_q, state_d;
    logic [EPMP_ADDR_W-1:0] retAddr_q, retAddr_d;
    logic [EPMP_ADDR_W-1:0] tgt_q, tgt_d;
    logic [EPMP_ADDR_W-1:0] pcOut_q, pcOut_d;
    logic                   driveIb;

    // Next-state and strobe decode. All strobes are decoded from the state
    // register alone, so an asynchronous reset removes them immediately and
    // nothing partial can appear after reset is released.
    // The popped word is captured straight into the PC output register at the
    // end of RET, which doubles as the pop register; PC_Out then holds it until
    // the next load.
    always_comb begin
        state_d    = state_q;
        retAddr_d  = retAddr_q;
        tgt_d      = tgt_q;
        pcOut_d    = pcOut_q;
        Push_Stack = 1'b0;
        Pop_Stack  = 1'b0;
        PC_Load    = 1'b0;
        Done       = 1'b0;
        Busy       = 1'b1;
        driveIb    = 1'b0;
        case (state_q)
            IDLE: begin
                Busy = 1'b0;
                if (Call_Req) begin
                    retAddr_d = PC_In + 16'd1;
                    tgt_d     = Target;
                    state_d   = CALL;
                end else if (Ret_Req) begin
                    state_d = RET;
                end
            end
            CALL: begin
                driveIb    = 1'b1;
                Push_Stack = 1'b1;
                pcOut_d    = tgt_q;
                state_d    = CLOAD;
            end
            CLOAD: begin
                PC_Load = 1'b1;
                Done    = 1'b1;
                state_d = IDLE;
            end
            RET: begin
                Pop_Stack = 1'b1;
                pcOut_d   = {IBH, IBL};
                state_d   = RLOAD;
            end
            RLOAD: begin
                PC_Load = 1'b1;
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                Busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            retAddr_q <= '0;
            tgt_q     <= '0;
            pcOut_q   <= '0;
        end else begin
            state_q   <= state_d;
            retAddr_q <= retAddr_d;
            tgt_q     <= tgt_d;
            pcOut_q   <= pcOut_d;
        end
    end

    // The bus is only ever driven while pushing; in RET the stack owns it.
    assign IBH    = driveIb ? retAddr_q[15:8] : 8'hzz;
    assign IBL    = driveIb ? retAddr_q[7:0]  : 8'hzz;
    assign PC_Out = pcOut_q;

    // Occupancy and sticky flag bookkeeping.
    epmp_depth_tracker #(
        .STACK_DEPTH (STACK_DEPTH),
        .DEPTH_W     (DEPTH_W)
    ) u_depth (
        .clk_i      (clk),
        .rst_i      (Reset),
        .push_i     (Push_Stack),
        .pop_i      (Pop_Stack),
        .flag_clr_i (Flag_Clr),
        .depth_o    (Depth),
        .ovf_o      (Ovf),
        .unf_o      (Unf)
    );

endmodule

// File: tb/tb_epmp_call_ret_ctrl.sv
// -----------------------------------------------------------------------------
// tb_epmp_call_ret_ctrl
// Directed bench for the EPMP call/return sequencer, attached to a small
// behavioural 4-entry EPMP stack sharing IBH/IBL.
// -----------------------------------------------------------------------------
module tb_epmp_call_ret_ctrl;

    logic        clk;
    logic        Reset;
    logic        Call_Req;
    logic        Ret_Req;
    logic [15:0] Target;
    logic [15:0] PC_In;
    logic        Flag_Clr;
    logic        Push_Stack;
    logic        Pop_Stack;
    wire  [7:0]  IBH;
    wire  [7:0]  IBL;
    logic [15:0] PC_Out;
    logic        PC_Load;
    logic        Busy;
    logic        Done;
    logic [2:0]  Depth;
    logic        Ovf;
    logic        Unf;

    int testsRun;
    int failCount;

    logic [15:0] stk [4];
    int          stkCnt;
    logic [15:0] stkTop;

    epmp_call_ret_ctrl #(
        .STACK_DEPTH (4),
        .DEPTH_W     (3)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .Call_Req   (Call_Req),
        .Ret_Req    (Ret_Req),
        .Target     (Target),
        .PC_In      (PC_In),
        .Flag_Clr   (Flag_Clr),
        .Push_Stack (Push_Stack),
        .Pop_Stack  (Pop_Stack),
        .IBH        (IBH),
        .IBL        (IBL),
        .PC_Out     (PC_Out),
        .PC_Load    (PC_Load),
        .Busy       (Busy),
        .Done       (Done),
        .Depth      (Depth),
        .Ovf        (Ovf),
        .Unf        (Unf)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural EPMP stack: drives the top entry (or 0000 when empty) onto
    // the bus while Pop_Stack is high; a push into a full stack drops the
    // oldest entry.
    assign stkTop = (stkCnt > 0) ? stk[stkCnt-1] : 16'h0000;
    assign IBH    = Pop_Stack ? stkTop[15:8] : 8'hzz;
    assign IBL    = Pop_Stack ? stkTop[7:0]  : 8'hzz;

    always @(posedge clk or posedge Reset) begin
        if (Reset) begin
            stkCnt <= 0;
        end else if (Push_Stack) begin
            if (stkCnt == 4) begin
                for (int i = 0; i < 3; i++) stk[i] <= stk[i+1];
                stk[3] <= {IBH, IBL};
            end else begin
                stk[stkCnt] <= {IBH, IBL};
                stkCnt      <= stkCnt + 1;
            end
        end else if (Pop_Stack) begin
            if (stkCnt > 0) stkCnt <= stkCnt - 1;
        end
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drives the decoder-side inputs for the coming edge.
    task automatic applyStimulus(input logic call, input logic ret,
                                 input logic [15:0] pc, input logic [15:0] tgt,
                                 input logic clr);
        Call_Req = call;
        Ret_Req  = ret;
        PC_In    = pc;
        Target   = tgt;
        Flag_Clr = clr;
    endtask

    // Full CALL sequence with checks in the CALL, CLOAD and following IDLE cycles.
    task automatic runCall(input string tag, input logic [15:0] pc,
                           input logic [15:0] tgt, input logic [15:0] expIb,
                           input int expDepth, input logic expOvf);
        applyStimulus(1'b1, 1'b0, pc, tgt, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        checkOutput({tag, "_push"}, 32'(Push_Stack), 32'd1);
        checkOutput({tag, "_ib"}, 32'({IBH, IBL}), 32'(expIb));
        checkOutput({tag, "_busy"}, 32'(Busy), 32'd1);
        @(posedge clk); #1;
        checkOutput({tag, "_pcload"}, 32'({PC_Load, Done, Push_Stack}), 32'b110);
        checkOutput({tag, "_pcout"}, 32'(PC_Out), 32'(tgt));
        checkOutput({tag, "_depth"}, 32'(Depth), 32'(expDepth));
        checkOutput({tag, "_ovf"}, 32'(Ovf), 32'(expOvf));
        @(posedge clk); #1;
        checkOutput({tag, "_idle"}, 32'({Busy, PC_Load, Done}), 32'b000);
    endtask

    // Full RET sequence with checks in the RET and RLOAD cycles.
    task automatic runRet(input string tag, input logic [15:0] expPc,
                          input int expDepth, input logic expUnf);
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        checkOutput({tag, "_pop"}, 32'({Pop_Stack, Push_Stack, Busy}), 32'b101);
        @(posedge clk); #1;
        checkOutput({tag, "_pcload"}, 32'({PC_Load, Done, Pop_Stack}), 32'b110);
        checkOutput({tag, "_pcout"}, 32'(PC_Out), 32'(expPc));
        checkOutput({tag, "_depth"}, 32'(Depth), 32'(expDepth));
        checkOutput({tag, "_unf"}, 32'(Unf), 32'(expUnf));
        @(posedge clk); #1;
    endtask

    initial begin
        testsRun  = 0;
        failCount = 0;
        Reset     = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        repeat (2) @(posedge clk);
        #1 Reset = 1'b0;
        @(posedge clk); #1;

        checkOutput("rst_strobes", 32'({Push_Stack, Pop_Stack, PC_Load, Busy, Done}), 32'd0);
        checkOutput("rst_flags", 32'({Ovf, Unf}), 32'd0);
        checkOutput("rst_pcout", 32'(PC_Out), 32'h0000);
        checkOutput("rst_depth", 32'(Depth), 32'd0);

        // Test 1/2: basic call and matching return
        runCall("t1", 16'h1234, 16'h0800, 16'h1235, 1, 1'b0);
        checkOutput("t1_pchold", 32'(PC_Out), 32'h0800);
        runRet("t2", 16'h1235, 0, 1'b0);

        // Test 3: overflow after five calls, four returns give newest four
        runCall("t3c1", 16'h0100, 16'h1000, 16'h0101, 1, 1'b0);
        runCall("t3c2", 16'h0200, 16'h2000, 16'h0201, 2, 1'b0);
        runCall("t3c3", 16'h0300, 16'h3000, 16'h0301, 3, 1'b0);
        runCall("t3c4", 16'h0400, 16'h4000, 16'h0401, 4, 1'b0);
        runCall("t3c5", 16'h0500, 16'h5000, 16'h0501, 4, 1'b1);
        runRet("t3r1", 16'h0501, 3, 1'b0);
        runRet("t3r2", 16'h0401, 2, 1'b0);
        runRet("t3r3", 16'h0301, 1, 1'b0);
        runRet("t3r4", 16'h0201, 0, 1'b0);
        checkOutput("t3_ovf_sticky", 32'(Ovf), 32'd1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        checkOutput("t3_ovf_clr", 32'(Ovf), 32'd0);

        // Test 4: underflow returns 0000, PC wrap on call from FFFF
        runRet("t4r", 16'h0000, 0, 1'b1);
        runCall("t4c", 16'hFFFF, 16'h2000, 16'h0000, 1, 1'b0);
        checkOutput("t4_unf_sticky", 32'(Unf), 32'd1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        checkOutput("t4_unf_clr", 32'(Unf), 32'd0);

        // Test 5: CALL wins over simultaneous RET; RET while busy ignored
        applyStimulus(1'b1, 1'b1, 16'h0040, 16'h3000, 1'b0);
        @(posedge clk); #1;
        Call_Req = 1'b0;
        checkOutput("t5_push", 32'({Push_Stack, Pop_Stack}), 32'b10);
        checkOutput("t5_ib", 32'({IBH, IBL}), 32'h0041);
        @(posedge clk); #1;
        Ret_Req = 1'b0;
        checkOutput("t5_cload", 32'({PC_Load, Pop_Stack}), 32'b10);
        checkOutput("t5_pcout", 32'(PC_Out), 32'h3000);
        @(posedge clk); #1;
        checkOutput("t5_ignored", 32'({Busy, Pop_Stack}), 32'b00);
        checkOutput("t5_depth", 32'(Depth), 32'd2);

        // Test 6: asynchronous reset in CALL state, then a clean call/return
        applyStimulus(1'b1, 1'b0, 16'h5555, 16'h6666, 1'b0);
        @(posedge clk); #1;
        Call_Req = 1'b0;
        checkOutput("t6_incall", 32'(Push_Stack), 32'd1);
        #2 Reset = 1'b1;
        #1;
        checkOutput("t6_async", 32'({Push_Stack, Busy, PC_Load, Done}), 32'd0);
        checkOutput("t6_depth", 32'(Depth), 32'd0);
        #3 Reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("t6_after", 32'({Push_Stack, Pop_Stack, Busy, PC_Load}), 32'd0);
        runCall("t6c", 16'h0AB0, 16'h0C00, 16'h0AB1, 1, 1'b0);
        runRet("t6r", 16'h0AB1, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
